ram_stream_fifo_ctrl: RTL and testbench
=======================================

# ram_stream_fifo_ctrl

Controller that turns the 64x8 single-port RAM (one write port, registered read address) into a synchronous valid/ready stream FIFO. It sits directly upstream and downstream of the RAM. It drives the RAM's write enable, data, write address and read address, and consumes the RAM's q. A 2-entry output buffer absorbs the RAM's one-cycle read latency so the block sustains one word per clock.

## Interface
- DW, 8, data width; equals the RAM data width.
- AW, 6, address width; RAM depth is DEPTH = 2**AW = 64.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  block can accept a word; registered.
- s_data  input  DW  upstream word.
- m_valid  output  1  head word valid; registered.
- m_ready  input  1  downstream accepts the head word.
- m_data  output  DW  head word of the output buffer.
- fill  output  AW+1  words held in RAM and not yet read-issued, 0..64.
- ram_we  output  1  drives RAM we.
- ram_data  output  DW  drives RAM data.
- ram_write_addr  output  AW  drives RAM write_addr.
- ram_read_addr  output  AW  drives RAM read_addr.
- ram_q  input  DW  RAM q; holds mem[read address latched at the previous edge].

## Operation
- State:
  - wr_ptr, rd_ptr: AW bits each, wrap 63 -> 0 naturally.
  - cnt: AW+1 bits, drives fill.
  - inflight: 1 bit, set when a read was issued in the previous cycle.
  - ob[0..1] with ob_cnt 0..2: output buffer, head at ob[0].
- Push = s_valid && s_ready.
  - Combinationally drives ram_we = push, ram_write_addr = wr_ptr, ram_data = s_data.
  - wr_ptr increments at the edge.
- ram_read_addr = rd_ptr at all times. ram_q is ignored unless inflight = 1.
- Pop = m_valid && m_ready.
- Issue = (cnt != 0) && (ob_cnt + inflight - pop < 2).
  - On issue, rd_ptr increments at the edge and inflight <= 1; otherwise inflight <= 0.
- Capture: when inflight = 1, ram_q is written into the output buffer at the next free slot after any pop in the same cycle.
  - The buffer never overflows, by construction of the issue condition.
- Pop shifts ob[1] to ob[0].
  - m_data = ob[0].
  - m_valid = (ob_cnt != 0).
- cnt_next = cnt + push - issue.
- s_ready_next = (cnt_next != DEPTH).
  - A slot freed by an issue while full reopens s_ready on the following cycle, not the same cycle.
- No read-during-write hazard: a word becomes issuable only in the cycle after it is written.
- Total capacity is 66 words: 64 in RAM plus 2 in the output buffer.
- Order is strictly FIFO. No data is ever duplicated or dropped.

## Timing
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = 0, cnt = 0, inflight = 0, ob_cnt = 0.
  - m_valid = 0, s_ready = 0, fill = 0.
  - ram_we = 0 while s_ready = 0.
  - m_data = 0 (buffer registers cleared).
  - RAM contents are not cleared.
- First rising edge after rst_n deasserts: s_ready <= 1.
- Latency with the block empty, from a push in cycle 0:
  - cycle 1: issue;
  - cycle 2: ram_q valid, captured at the end of the cycle;
  - cycle 3: m_valid = 1 with that word.
- Throughput: 1 push and 1 pop per cycle sustained, including simultaneous push and pop at any fill level.
- Full: cnt = 64 → s_ready = 0, ram_we = 0 regardless of s_valid.
- Empty: cnt = 0 → no issue, rd_ptr holds.
- Reset asserted mid-operation:
  - All buffered and in-flight words are discarded.
  - Outputs take their reset values immediately.
- m_valid stays asserted and m_data stays stable until popped; the downstream may hold m_ready low indefinitely.

## Test plan
- Reset, release, drive nothing → s_ready = 1 from the 1st edge, m_valid = 0, fill = 0, ram_we never 1.
- Push 0x5A in cycle 0 with m_ready = 1 → ram_we = 1 with ram_write_addr = 0 in cycle 0; m_valid = 1 and m_data = 0x5A in cycle 3; fill returns to 0.
- m_ready = 0, push 0x00..0x45 (70 words) → exactly 66 accepted; s_ready = 0 once fill = 64 with 2 words buffered. Then m_ready = 1 → 0x00..0x41 out in order with no gaps after the first.
- Continuous push and pop of an incrementing byte for 200 cycles → 1 word per cycle out after the 3-cycle latency; both pointers wrap past 63 with no loss or reordering.
- Random s_valid/m_ready (50% each), 1000 words → output sequence equals input sequence; fill never exceeds 64; m_data is stable while m_valid && !m_ready.
- Fill 10 words, pulse rst_n low mid-stream → m_valid = 0 and fill = 0 asynchronously. After release, pushing 0xA1 yields 0xA1 as the first output word.

Source files
------------

// File: rtl/ram_stream_fifo_ctrl.sv
// Valid/ready stream FIFO built around a 64x8 single-port RAM with a registered read address.
// A 2-entry output buffer hides the RAM read latency so one word per clock flows through.
module ram_stream_fifo_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW:0]   fill,
  output logic          ram_we,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_write_addr,
  output logic [AW-1:0] ram_read_addr,
  input  logic [DW-1:0] ram_q
);

  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          inflight, inflight_n;
  logic [DW-1:0] ob0, ob0_n, ob1, ob1_n;
  logic [1:0]    ob_cnt, ob_cnt_n, ob_base;
  logic          s_ready_n, m_valid_n;
  logic          push, pop, issue;
  logic [2:0]    occ;

  // Next-state: push/issue bookkeeping and output-buffer shift/capture
  always_comb begin
    push       = s_valid && s_ready;
    pop        = m_valid && m_ready;
    occ        = 3'(ob_cnt) + 3'(inflight) - 3'(pop);
    issue      = (cnt != '0) && (occ < 3'd2);
    wr_ptr_n   = wr_ptr + AW'(push);
    rd_ptr_n   = rd_ptr + AW'(issue);
    cnt_n      = cnt + CW'(push) - CW'(issue);
    inflight_n = issue;
    ob0_n      = ob0;
    ob1_n      = ob1;
    if (pop) ob0_n = ob1;
    ob_base    = ob_cnt - 2'(pop);
    // Returning RAM word lands in the first free slot after this cycle's pop
    if (inflight) begin
      if (ob_base == 2'd0) ob0_n = ram_q;
      else                 ob1_n = ram_q;
    end
    ob_cnt_n   = ob_base + 2'(inflight);
    m_valid_n  = (ob_cnt_n != 2'd0);
    s_ready_n  = (cnt_n != CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
      ob0      <= '0;
      ob1      <= '0;
      ob_cnt   <= 2'd0;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      cnt      <= cnt_n;
      inflight <= inflight_n;
      ob0      <= ob0_n;
      ob1      <= ob1_n;
      ob_cnt   <= ob_cnt_n;
      s_ready  <= s_ready_n;
      m_valid  <= m_valid_n;
    end
  end

  assign ram_we         = push;
  assign ram_data       = s_data;
  assign ram_write_addr = wr_ptr;
  assign ram_read_addr  = rd_ptr;
  assign m_data         = ob0;
  assign fill           = cnt;

endmodule

// File: tb/tb_ram_stream_fifo_ctrl.sv
// Self-checking bench for ram_stream_fifo_ctrl with a behavioural 64x8 registered-address RAM.
module tb_ram_stream_fifo_ctrl;

  logic       clk, rst_n;
  logic       s_valid, s_ready, m_valid, m_ready;
  logic [7:0] s_data, m_data, ram_data, ram_q;
  logic [6:0] fill;
  logic       ram_we;
  logic [5:0] ram_write_addr, ram_read_addr;

  ram_stream_fifo_ctrl #(.DW(8), .AW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fill(fill),
    .ram_we(ram_we), .ram_data(ram_data),
    .ram_write_addr(ram_write_addr), .ram_read_addr(ram_read_addr),
    .ram_q(ram_q)
  );

  // RAM model: write port plus read address latched at the edge
  logic [7:0] mem [64];
  logic [5:0] ra_q;
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ra_q <= ram_read_addr;
  end
  assign ram_q = mem[ra_q];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and stream statistics kept by the monitor
  logic [7:0] sb[$];
  int         n_push, n_pop, cyc, first_pop, last_pop;
  logic [7:0] first_data;
  logic       hold_prev;
  logic [7:0] hold_data;

  task automatic clear_stats();
    n_push = 0; n_pop = 0; cyc = 0; first_pop = -1; last_pop = -1;
  endtask

  task automatic monitor();
    logic [7:0] e;
    if (rst_n) begin
      check("fill_le_64", 32'(fill > 7'd64), 32'd0);
      if (hold_prev) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(hold_data));
      end
      if (s_valid && s_ready) begin
        sb.push_back(s_data);
        n_push++;
      end
      if (m_valid && m_ready) begin
        if (n_pop == 0) begin
          first_pop  = cyc;
          first_data = m_data;
        end
        last_pop = cyc;
        n_pop++;
        if (sb.size() == 0) begin
          check("pop_unexpected", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("order", 32'(m_data), 32'(e));
        end
      end
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
      cyc++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       e_sr;
    logic       e_mv;
    logic [7:0] e_md;
    logic [6:0] e_fill;
    logic       e_we;
    logic [5:0] e_wa;
  } vec_t;

  vec_t vecs[14];
  int   nxt;
  int   guard;

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 7'd0, 1'b0, 6'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 7'd0, 1'b0, 6'd0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0, 1'b0, 6'd0};
    vecs[3]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0, 1'b1, 6'd0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd1, 1'b0, 6'd0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0, 1'b0, 6'd0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 7'd0, 1'b0, 6'd0};
    vecs[7]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 7'd0, 1'b1, 6'd1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 7'd1, 1'b0, 6'd0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 7'd0, 1'b0, 6'd0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 7'd0, 1'b0, 6'd0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 7'd0, 1'b0, 6'd0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 7'd0, 1'b0, 6'd0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 7'd0, 1'b0, 6'd0};

    hold_prev = 1'b0; hold_data = 8'h00; first_data = 8'h00;
    clear_stats();

    // Reset state, with upstream already presenting a word
    rst_n = 1'b1; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_we_hold", 32'(ram_we), 32'd0);
    rst_n = 1'b1; s_valid = 1'b0; s_data = 8'h00;

    // Directed vectors: idle after release, single-word latency, hold under backpressure
    for (int i = 0; i < 14; i++) begin
      s_valid = vecs[i].sv; s_data = vecs[i].sd; m_ready = vecs[i].mr;
      @(negedge clk);
      check($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].e_sr));
      check($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
      if (vecs[i].e_mv) check($sformatf("v%0d_m_data", i), 32'(m_data), 32'(vecs[i].e_md));
      check($sformatf("v%0d_fill", i), 32'(fill), 32'(vecs[i].e_fill));
      check($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) check($sformatf("v%0d_waddr", i), 32'(ram_write_addr), 32'(vecs[i].e_wa));
      monitor();
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    check("vec_sb_empty", 32'(sb.size()), 32'd0);

    // Fill to capacity with the sink stalled: 64 in RAM plus 2 buffered
    clear_stats();
    nxt = 0;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1; s_data = 8'(nxt);
      @(negedge clk);
      if (s_ready) nxt++;
      monitor();
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("full_accepted", 32'(n_push), 32'd66);
    check("full_s_ready", 32'(s_ready), 32'd0);
    check("full_ram_we", 32'(ram_we), 32'd0);
    check("full_fill", 32'(fill), 32'd64);
    check("full_m_valid", 32'(m_valid), 32'd1);
    check("full_head", 32'(m_data), 32'h00);
    @(posedge clk);
    #1;
    s_valid = 1'b0; m_ready = 1'b1;
    clear_stats();
    for (int i = 0; i < 80; i++) step();
    check("drain_count", 32'(n_pop), 32'd66);
    check("drain_no_gap", 32'(last_pop - first_pop), 32'd65);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Sustained push+pop across pointer wrap
    clear_stats();
    for (int i = 0; i < 200; i++) begin
      s_valid = 1'b1; s_data = 8'(i); m_ready = 1'b1;
      step();
    end
    s_valid = 1'b0;
    check("stream_latency", 32'(first_pop), 32'd3);
    check("stream_pops", 32'(n_pop), 32'd197);
    for (int i = 0; i < 6; i++) step();
    check("stream_total", 32'(n_pop), 32'd200);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Random valid/ready, 1000 words
    clear_stats();
    guard = 0;
    while (n_push < 1000 && guard < 20000) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    check("rand_pushed", 32'(n_push), 32'd1000);
    s_valid = 1'b0; m_ready = 1'b1;
    guard = 0;
    while ((sb.size() != 0 || m_valid) && guard < 200) begin
      step();
      guard++;
    end
    check("rand_sb_empty", 32'(sb.size()), 32'd0);
    check("rand_pops", 32'(n_pop), 32'(n_push));

    // Asynchronous reset mid-stream discards everything
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h10 + i);
      step();
    end
    s_valid = 1'b0;
    repeat (3) step();
    check("pre_rst_fill", 32'(fill), 32'd8);
    check("pre_rst_m_valid", 32'(m_valid), 32'd1);
    s_valid = 1'b1; s_data = 8'hEE;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_fill", 32'(fill), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check("mid_rst_ram_we", 32'(ram_we), 32'd0);
    sb.delete();
    hold_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; s_valid = 1'b0;
    step();
    clear_stats();
    s_valid = 1'b1; s_data = 8'hA1; m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    guard = 0;
    while (n_pop == 0 && guard < 10) begin
      step();
      guard++;
    end
    check("post_rst_pops", 32'(n_pop), 32'd1);
    check("post_rst_first", 32'(first_data), 32'hA1);
    check("post_rst_latency", 32'(first_pop), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
